mips_core_units: RTL and testbench

MIPS_CORE_UNITS -- requirements
Module: mips_core_units

---
 rtl/mips_core_units_if.sv | 38 +++
 rtl/mips_core_units.sv | 203 ++++++++++++++++++++
 tb/tb_mips_core_units.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_core_units_if.sv
// -----------------------------------------------------------------------------
// mips_core_units_if
//   Data-memory bus shared between a requester and the core's data memory.
//
//   Signals
//     dm_addr   [31:0]  byte address (word index taken from the low bits)
//     dm_rd             read enable; dm_rdata is zero when low
//     dm_wr             write enable; the write commits on the rising clock edge
//     dm_wdata  [31:0]  write data
//     dm_rdata  [31:0]  combinational read data
//
//   Modports
//     master  drives address/enables/write data, receives read data
//     slave   the memory side
// -----------------------------------------------------------------------------
interface mips_core_units_if;
  logic [31:0] dm_addr;
  logic        dm_rd;
  logic        dm_wr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  modport master (
    output dm_addr,
    output dm_rd,
    output dm_wr,
    output dm_wdata,
    input  dm_rdata
  );

  modport slave (
    input  dm_addr,
    input  dm_rd,
    input  dm_wr,
    input  dm_wdata,
    output dm_rdata
  );
endinterface

// File: rtl/mips_core_units.sv
// -----------------------------------------------------------------------------
// mips_core_units
//   The three leaf units of a single-cycle MIPS datapath:
//     - main control decoder (opcode/funct -> control flags and ALU code)
//     - 32-bit ALU (AND, OR, ADD, SUB, SLT, NOR) with zero flag
//     - word-addressed data memory, combinational read, clocked write
//   Control and ALU are purely combinational; only the data memory uses
//   clk/reset.
//
//   Parameters
//     DM_WORDS   data-memory depth in 32-bit words (power of two, 2..1024)
//
//   Ports
//     clk, reset            clock; synchronous active-high reset (clears memory)
//     opcode, funct         instruction fields [31:26] and [5:0]
//     regdst .. jump        decoded control flags
//     aluctl                decoded ALU operation code
//     alu_op, a, b          ALU operation select and operands
//     alu_out, zero, ovf    ALU result, result-is-zero, signed overflow
//     dm                    data-memory bus (slave side)
//
//   Build option
//     ALU_OVF_EN  when defined, ovf flags signed overflow of ADD/SUB;
//                 otherwise ovf is tied low and no overflow logic exists.
// -----------------------------------------------------------------------------
module mips_core_units #(
  parameter int DM_WORDS = 128
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic        regdst,
  output logic        branch_eq,
  output logic        branch_ne,
  output logic        memread,
  output logic        memwrite,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        alusrc,
  output logic        jump,
  output logic [3:0]  aluctl,

  input  logic [3:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] alu_out,
  output logic        zero,
  output logic        ovf,

  mips_core_units_if.slave dm
);

  // ALU operation codes, shared by the decoder and the ALU.
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int IW = $clog2(DM_WORDS);

  // ---------------------------------------------------------------------------
  // Control decoder
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned; that is what keeps combinational blocks free of latches.
    regdst    = 1'b0;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    alusrc    = 1'b0;
    jump      = 1'b0;
    aluctl    = ALU_AND;

    unique case (opcode)
      OP_RTYPE: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        case (funct)
          6'b100000: aluctl = ALU_ADD;
          6'b100010: aluctl = ALU_SUB;
          6'b100100: aluctl = ALU_AND;
          6'b100101: aluctl = ALU_OR;
          6'b100111: aluctl = ALU_NOR;
          6'b101010: aluctl = ALU_SLT;
          // Unsupported funct: suppress the register write so nothing is
          // corrupted; regdst stays set as for any R-type.
          default: begin
            aluctl   = ALU_AND;
            regwrite = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        memread  = 1'b1;
        memtoreg = 1'b1;
        regwrite = 1'b1;
        alusrc   = 1'b1;
        aluctl   = ALU_ADD;
      end
      OP_SW: begin
        memwrite = 1'b1;
        alusrc   = 1'b1;
        aluctl   = ALU_ADD;
      end
      OP_BEQ: begin
        branch_eq = 1'b1;
        aluctl    = ALU_SUB;
      end
      OP_BNE: begin
        branch_ne = 1'b1;
        aluctl    = ALU_SUB;
      end
      OP_ADDI: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
        aluctl   = ALU_ADD;
      end
      OP_J: begin
        jump = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_out = '0;
    case (alu_op)
      ALU_AND: alu_out = a & b;
      ALU_OR:  alu_out = a | b;
      ALU_ADD: alu_out = a + b;
      ALU_SUB: alu_out = a - b;
      ALU_SLT: alu_out = {31'b0, ($signed(a) < $signed(b))};
      ALU_NOR: alu_out = ~(a | b);
      default: alu_out = '0;
    endcase
  end

  assign zero = (alu_out == 32'd0);

`ifdef ALU_OVF_EN
  // Signed overflow: operands (b inverted for SUB) share a sign that the
  // result does not.
  always_comb begin
    ovf = 1'b0;
    case (alu_op)
      ALU_ADD: ovf = (a[31] == b[31]) && (alu_out[31] != a[31]);
      ALU_SUB: ovf = (a[31] != b[31]) && (alu_out[31] != a[31]);
      default: ovf = 1'b0;
    endcase
  end
`else
  assign ovf = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Data memory
  // ---------------------------------------------------------------------------
  logic [31:0]   mem [DM_WORDS];
  logic [IW-1:0] idx;

  // Upper address bits wrap and byte-offset bits are ignored.
  assign idx = dm.dm_addr[IW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{dm.dm_addr[31:IW+2], dm.dm_addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this memory must read as zero after reset, so every word is
      // cleared here; that forces a flop array rather than a RAM macro.
      for (int i = 0; i < DM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (dm.dm_wr) begin
      // NOTE: non-blocking so a same-cycle read still sees the old word and
      // all flops update together at the edge.
      mem[idx] <= dm.dm_wdata;
    end
  end

  // Combinational read: a simultaneous write shows up only after the edge.
  assign dm.dm_rdata = dm.dm_rd ? mem[idx] : 32'd0;

endmodule

// File: tb/tb_mips_core_units.sv
// -----------------------------------------------------------------------------
// tb_mips_core_units
//   Directed self-checking bench for mips_core_units (DM_WORDS = 128).
//   Inputs change on the falling edge; outputs are sampled 1 time unit later,
//   well away from the rising edge where memory writes commit.
// -----------------------------------------------------------------------------
module tb_mips_core_units;

`ifdef ALU_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        regdst, branch_eq, branch_ne, memread, memwrite;
  logic        memtoreg, regwrite, alusrc, jump;
  logic [3:0]  aluctl;
  logic [3:0]  alu_op;
  logic [31:0] a, b;
  logic [31:0] alu_out;
  logic        zero, ovf;

  int checks = 0;
  int errors = 0;

  mips_core_units_if bus ();

  mips_core_units #(.DM_WORDS(128)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .regdst    (regdst),
    .branch_eq (branch_eq),
    .branch_ne (branch_ne),
    .memread   (memread),
    .memwrite  (memwrite),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .alusrc    (alusrc),
    .jump      (jump),
    .aluctl    (aluctl),
    .alu_op    (alu_op),
    .a         (a),
    .b         (b),
    .alu_out   (alu_out),
    .zero      (zero),
    .ovf       (ovf),
    .dm        (bus)
  );

  always #5 clk = ~clk;

  // {regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump}
  typedef struct packed {
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [8:0] flags;
    logic [3:0] aluctl;
  } ctrl_vec_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        zero;
    logic        ovf;
  } alu_vec_t;

  localparam int N_CTRL = 15;
  localparam ctrl_vec_t CTRL_VECS [N_CTRL] = '{
    '{6'b000000, 6'b100000, 9'b100000100, 4'd2},   // R add
    '{6'b000000, 6'b100010, 9'b100000100, 4'd6},   // R sub
    '{6'b000000, 6'b100100, 9'b100000100, 4'd0},   // R and
    '{6'b000000, 6'b100101, 9'b100000100, 4'd1},   // R or
    '{6'b000000, 6'b100111, 9'b100000100, 4'd12},  // R nor
    '{6'b000000, 6'b101010, 9'b100000100, 4'd7},   // R slt
    '{6'b000000, 6'b000011, 9'b100000000, 4'd0},   // R unknown funct
    '{6'b100011, 6'b100000, 9'b000101110, 4'd2},   // LW
    '{6'b101011, 6'b101010, 9'b000010010, 4'd2},   // SW
    '{6'b000100, 6'b100000, 9'b010000000, 4'd6},   // BEQ
    '{6'b000101, 6'b100000, 9'b001000000, 4'd6},   // BNE
    '{6'b001000, 6'b100111, 9'b000000110, 4'd2},   // ADDI
    '{6'b000010, 6'b100000, 9'b000000001, 4'd0},   // J
    '{6'b001101, 6'b100000, 9'b000000000, 4'd0},   // ORI (unsupported)
    '{6'b111111, 6'b101010, 9'b000000000, 4'd0}    // unsupported
  };

  localparam int N_ALU = 14;
  localparam alu_vec_t ALU_VECS [N_ALU] = '{
    '{4'd6,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0},
    '{4'd7,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0},
    '{4'd2,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, OVF_ON},
    '{4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0},
    '{4'd1,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 1'b0},
    '{4'd12, 32'h0000_FFFF, 32'h00FF_0000, 32'hFF00_0000, 1'b0, 1'b0},
    '{4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0},
    '{4'd6,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, OVF_ON},
    '{4'd6,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0},
    '{4'd7,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0},
    '{4'd7,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0},
    '{4'd3,  32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0},
    '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0},
    '{4'd2,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, OVF_ON}
  };

  // Stimulus helpers (no checking inside).
  task automatic dm_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.dm_addr  = addr;
    bus.dm_wdata = data;
    bus.dm_wr    = 1'b1;
    bus.dm_rd    = 1'b0;
    @(posedge clk);
    #1;
    bus.dm_wr    = 1'b0;
  endtask

  task automatic dm_read_setup(input logic [31:0] addr);
    @(negedge clk);
    bus.dm_addr = addr;
    bus.dm_rd   = 1'b1;
    bus.dm_wr   = 1'b0;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] addrs [3];
    addrs[0] = 32'h0000_0000;
    addrs[1] = 32'h0000_0010;
    addrs[2] = 32'h0000_01FC;

    reset        = 1'b1;
    bus.dm_rd    = 1'b0;
    bus.dm_wr    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    opcode       = 6'b100011;
    funct        = 6'b000000;
    alu_op       = 4'd2;
    a            = 32'd2;
    b            = 32'd3;
    @(posedge clk);
    @(negedge clk);

    // Reset must not disturb the combinational units.
    checks++;
    if ({regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump} !== 9'b000101110
        || aluctl !== 4'd2) begin
      errors++;
      $display("FAIL reset_ctrl: flags=%b aluctl=%0d, want flags=000101110 aluctl=2",
               {regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump}, aluctl);
    end
    checks++;
    if (alu_out !== 32'd5 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_alu: alu_out=%h zero=%b, want 00000005 0", alu_out, zero);
    end

    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dm_read_setup(addrs[i]);
      checks++;
      if (bus.dm_rdata !== 32'd0) begin
        errors++;
        $display("FAIL reset_read addr=%h: got %h, want 00000000", addrs[i], bus.dm_rdata);
      end
    end
    bus.dm_rd = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_control();
    logic [8:0] flags;
    for (int i = 0; i < N_CTRL; i++) begin
      opcode = CTRL_VECS[i].opcode;
      funct  = CTRL_VECS[i].funct;
      #1;
      flags = {regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump};
      checks++;
      if (flags !== CTRL_VECS[i].flags || aluctl !== CTRL_VECS[i].aluctl) begin
        errors++;
        $display("FAIL ctrl op=%b funct=%b: flags=%b aluctl=%0d, want flags=%b aluctl=%0d",
                 opcode, funct, flags, aluctl, CTRL_VECS[i].flags, CTRL_VECS[i].aluctl);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_alu();
    for (int i = 0; i < N_ALU; i++) begin
      alu_op = ALU_VECS[i].op;
      a      = ALU_VECS[i].a;
      b      = ALU_VECS[i].b;
      #1;
      checks++;
      if (alu_out !== ALU_VECS[i].out || zero !== ALU_VECS[i].zero || ovf !== ALU_VECS[i].ovf) begin
        errors++;
        $display("FAIL alu op=%0d a=%h b=%h: out=%h zero=%b ovf=%b, want out=%h zero=%b ovf=%b",
                 alu_op, a, b, alu_out, zero, ovf,
                 ALU_VECS[i].out, ALU_VECS[i].zero, ALU_VECS[i].ovf);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_dm();
    logic [31:0] raddr [6];
    logic [31:0] rexp  [6];
    raddr[0] = 32'h0000_0010; rexp[0] = 32'hDEAD_BEEF;
    raddr[1] = 32'h0000_0013; rexp[1] = 32'hDEAD_BEEF;  // byte offset ignored
    raddr[2] = 32'h0000_0210; rexp[2] = 32'hDEAD_BEEF;  // wraps to index 4
    raddr[3] = 32'h0000_0014; rexp[3] = 32'h0000_0000;  // neighbour untouched
    raddr[4] = 32'h0000_01FC; rexp[4] = 32'h1234_5678;  // top word
    raddr[5] = 32'hFFFF_FFFF; rexp[5] = 32'h1234_5678;  // wraps to index 127

    dm_write(32'h0000_0010, 32'hDEAD_BEEF);
    dm_write(32'h0000_01FC, 32'h1234_5678);
    for (int i = 0; i < 6; i++) begin
      dm_read_setup(raddr[i]);
      checks++;
      if (bus.dm_rdata !== rexp[i]) begin
        errors++;
        $display("FAIL dm_read addr=%h: got %h, want %h", raddr[i], bus.dm_rdata, rexp[i]);
      end
    end

    // Read enable low forces zero even on a populated word.
    bus.dm_addr = 32'h0000_0010;
    bus.dm_rd   = 1'b0;
    #1;
    checks++;
    if (bus.dm_rdata !== 32'd0) begin
      errors++;
      $display("FAIL dm_rd_low: got %h, want 00000000", bus.dm_rdata);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_read_during_write();
    dm_write(32'h0000_0020, 32'd7);
    @(negedge clk);
    bus.dm_addr  = 32'h0000_0020;
    bus.dm_wdata = 32'd9;
    bus.dm_rd    = 1'b1;
    bus.dm_wr    = 1'b1;
    #1;
    checks++;
    if (bus.dm_rdata !== 32'd7) begin
      errors++;
      $display("FAIL rdw_before: got %0d, want 7", bus.dm_rdata);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.dm_rdata !== 32'd9) begin
      errors++;
      $display("FAIL rdw_after: got %0d, want 9", bus.dm_rdata);
    end
    bus.dm_wr = 1'b0;
    bus.dm_rd = 1'b0;
    #1;
    checks++;
    if (bus.dm_rdata !== 32'd0) begin
      errors++;
      $display("FAIL rdw_rd_low: got %0d, want 0", bus.dm_rdata);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_clears();
    logic [31:0] addrs [4];
    addrs[0] = 32'h0000_0010;
    addrs[1] = 32'h0000_0020;
    addrs[2] = 32'h0000_0030;
    addrs[3] = 32'h0000_01FC;

    dm_write(32'h0000_0030, 32'h5555_5555);
    // One reset cycle with a write pending: the write must be dropped.
    @(negedge clk);
    reset        = 1'b1;
    bus.dm_addr  = 32'h0000_0030;
    bus.dm_wdata = 32'hAAAA_AAAA;
    bus.dm_wr    = 1'b1;
    bus.dm_rd    = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
    bus.dm_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dm_read_setup(addrs[i]);
      checks++;
      if (bus.dm_rdata !== 32'd0) begin
        errors++;
        $display("FAIL reset_clear addr=%h: got %h, want 00000000", addrs[i], bus.dm_rdata);
      end
    end
    bus.dm_rd = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_control();
    test_alu();
    test_dm();
    test_read_during_write();
    test_reset_clears();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
